rv_plic_claim_ctrl: RTL and testbench

//  Per-target claim/complete sequencer for the PLIC. Per-source level gateways latch pending (IP)
//  and track in-service (active) state. IP feeds the priority target, which returns the winning
//  irq/id. Claims are serialized so each claim sees a target result that reflects prior IP clears.

---
 rtl/rv_plic_ctrl_pkg.sv | 18 +
 rtl/rv_plic_gateway.sv | 38 +++
 rtl/rv_plic_claim_ctrl.sv | 129 ++++++++++++
 tb/tb_rv_plic_claim_ctrl.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_plic_ctrl_pkg.sv
// Shared types and sizing helpers for the PLIC claim/complete controller.
package rv_plic_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RESP,
      SETTLE
   } claim_state_e;

   localparam int SETTLE_CYCLES_DEFAULT = 2;
   localparam int SETTLE_CNT_W          = $clog2(SETTLE_CYCLES_DEFAULT + 1);

   // Counter width for an arbitrary lockout length; never narrower than one bit.
   function automatic int settle_cnt_w(input int settle_cycles);
      return (settle_cycles < 1) ? 1 : $clog2(settle_cycles + 1);
   endfunction

endpackage

// File: rtl/rv_plic_gateway.sv
// Level-triggered gateway for one interrupt source: latches pending and tracks in-service.
module rv_plic_gateway (
   input  logic clk_i,
   input  logic rst_i,
   input  logic src_i,
   input  logic claim_i,
   input  logic complete_i,
   output logic ip_o,
   output logic active_o
);

   logic ip_reg;
   logic active_reg;

   // Set looks at registered active, so a completed source re-pends one edge later at the earliest.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ip_reg     <= 1'b0;
         active_reg <= 1'b0;
      end else begin
         if (claim_i) begin
            ip_reg <= 1'b0;
         end else if (src_i && !active_reg) begin
            ip_reg <= 1'b1;
         end

         if (claim_i) begin
            active_reg <= 1'b1;
         end else if (complete_i) begin
            active_reg <= 1'b0;
         end
      end
   end

   assign ip_o     = ip_reg;
   assign active_o = active_reg;

endmodule

// File: rtl/rv_plic_claim_ctrl.sv
// Per-target claim/complete sequencer: serializes claims, drives gateways, flags bad completes.
module rv_plic_claim_ctrl
   import rv_plic_ctrl_pkg::*;
#(
   parameter  int N_SOURCE      = 32,
   parameter  int SETTLE_CYCLES = SETTLE_CYCLES_DEFAULT,
   localparam int SrcWidth      = $clog2(N_SOURCE)
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [N_SOURCE-1:0] src_i,
   input  logic                irq_i,
   input  logic [SrcWidth-1:0] irq_id_i,
   output logic [N_SOURCE-1:0] ip_o,
   output logic [N_SOURCE-1:0] active_o,
   input  logic                claim_valid_i,
   output logic                claim_ready_o,
   output logic                claim_rvalid_o,
   output logic [SrcWidth-1:0] claim_id_o,
   input  logic                complete_i,
   input  logic [SrcWidth-1:0] complete_id_i,
   output logic                complete_err_o
);

   localparam int CntW = settle_cnt_w(SETTLE_CYCLES);
   localparam int IdxN = 1 << SrcWidth;
   localparam logic [CntW-1:0] SettleLoad = CntW'(SETTLE_CYCLES - 1);

   claim_state_e        state_reg, state_next;
   logic [CntW-1:0]     cnt_reg, cnt_next;
   logic [SrcWidth-1:0] claim_id_reg;
   logic                err_reg;

   logic [N_SOURCE-1:0] ip_vec;
   logic [N_SOURCE-1:0] active_vec;
   logic [IdxN-1:0]     ip_ext;
   logic [IdxN-1:0]     active_ext;
   logic                handshake;
   logic                grant_valid;
   logic [SrcWidth-1:0] grant_id;
   logic                complete_bad;
   logic                src0_unused;

   // Source 0 is the reserved "no interrupt" ID and has no gateway.
   assign src0_unused   = src_i[0];
   assign ip_vec[0]     = 1'b0;
   assign active_vec[0] = 1'b0;

   // Zero-padded views so out-of-range IDs index a 0 rather than falling off the vector.
   assign ip_ext     = IdxN'(ip_vec);
   assign active_ext = IdxN'(active_vec);

   assign claim_ready_o = (state_reg == IDLE) && !rst_i;
   assign handshake     = claim_valid_i && claim_ready_o;
   assign grant_valid   = handshake && irq_i && ip_ext[irq_id_i];
   assign grant_id      = grant_valid ? irq_id_i : '0;

   // A complete racing the claim of the same ID targets that claim, so it is not an error.
   assign complete_bad = !active_ext[complete_id_i] &&
                         !(grant_valid && (grant_id == complete_id_i));

   generate
      for (genvar gi = 1; gi < N_SOURCE; gi++) begin : g_src
         logic grant_hit;
         logic complete_hit;

         assign grant_hit    = grant_valid && (irq_id_i == SrcWidth'(gi));
         assign complete_hit = complete_i && (complete_id_i == SrcWidth'(gi));

         rv_plic_gateway u_gateway (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .src_i      (src_i[gi]),
            .claim_i    (grant_hit),
            .complete_i (complete_hit),
            .ip_o       (ip_vec[gi]),
            .active_o   (active_vec[gi])
         );
      end
   endgenerate

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      case (state_reg)
         IDLE: begin
            if (handshake) begin
               state_next = RESP;
            end
         end
         RESP: begin
            cnt_next   = SettleLoad;
            state_next = (SETTLE_CYCLES > 1) ? SETTLE : IDLE;
         end
         SETTLE: begin
            cnt_next = cnt_reg - CntW'(1);
            if (cnt_reg == CntW'(1)) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg    <= IDLE;
         cnt_reg      <= '0;
         claim_id_reg <= '0;
         err_reg      <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         if (handshake) begin
            claim_id_reg <= grant_id;
         end
         err_reg <= complete_i && complete_bad;
      end
   end

   assign ip_o           = ip_vec;
   assign active_o       = active_vec;
   assign claim_rvalid_o = (state_reg == RESP);
   assign claim_id_o     = claim_id_reg;
   assign complete_err_o = err_reg;

endmodule

// File: tb/tb_rv_plic_claim_ctrl.sv
// Self-checking bench: directed scenarios plus randomized traffic against a behavioural model.
module tb_rv_plic_claim_ctrl;

   localparam int N  = 32;
   localparam int SC = 2;
   localparam int W  = 5;

   logic          clk = 1'b0;
   logic          rst_i;
   logic [N-1:0]  src_i;
   logic          irq_i;
   logic [W-1:0]  irq_id_i;
   logic [N-1:0]  ip_o;
   logic [N-1:0]  active_o;
   logic          claim_valid_i;
   logic          claim_ready_o;
   logic          claim_rvalid_o;
   logic [W-1:0]  claim_id_o;
   logic          complete_i;
   logic [W-1:0]  complete_id_i;
   logic          complete_err_o;

   always #5 clk = ~clk;

   rv_plic_claim_ctrl #(.N_SOURCE(N), .SETTLE_CYCLES(SC)) dut (
      .clk_i          (clk),
      .rst_i          (rst_i),
      .src_i          (src_i),
      .irq_i          (irq_i),
      .irq_id_i       (irq_id_i),
      .ip_o           (ip_o),
      .active_o       (active_o),
      .claim_valid_i  (claim_valid_i),
      .claim_ready_o  (claim_ready_o),
      .claim_rvalid_o (claim_rvalid_o),
      .claim_id_o     (claim_id_o),
      .complete_i     (complete_i),
      .complete_id_i  (complete_id_i),
      .complete_err_o (complete_err_o)
   );

   // Behavioural model: per-source flags, a lockout countdown, and the last response.
   bit m_ip  [N];
   bit m_act [N];
   int m_lock;
   bit m_rvalid;
   bit m_err;
   int m_id;

   // Target model: a registered "highest pending ID wins" view of the previous cycle.
   bit tgt_mode;
   bit tgt_irq;
   int tgt_id;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", name, act, exp);
      end
   endtask

   function automatic logic [N-1:0] pack(input bit v [N]);
      logic [N-1:0] r;
      for (int i = 0; i < N; i++) r[i] = v[i];
      return r;
   endfunction

   task automatic compare_all();
      chk("ip",     ip_o,           pack(m_ip));
      chk("active", active_o,       pack(m_act));
      chk("ready",  claim_ready_o,  (m_lock == 0) && !rst_i);
      chk("rvalid", claim_rvalid_o, m_rvalid);
      chk("id",     claim_id_o,     m_id);
      chk("err",    complete_err_o, m_err);
   endtask

   // One clock: evaluate the model on the current inputs, take the edge, commit, compare.
   task automatic step();
      bit nip  [N];
      bit nact [N];
      bit hs;
      int g;
      int cid;
      int best;
      if (tgt_mode) begin
         irq_i    = tgt_irq;
         irq_id_i = W'(tgt_id);
      end
      best = 0;
      for (int i = 1; i < N; i++) if (m_ip[i]) best = i;
      cid = int'(complete_id_i);
      if (rst_i) begin
         for (int i = 0; i < N; i++) begin
            nip[i]  = 1'b0;
            nact[i] = 1'b0;
         end
         @(posedge clk);
         #1;
         m_ip     = nip;
         m_act    = nact;
         m_lock   = 0;
         m_rvalid = 1'b0;
         m_err    = 1'b0;
         m_id     = 0;
      end else begin
         hs = claim_valid_i && (m_lock == 0);
         g  = (hs && irq_i && irq_id_i != 0 && m_ip[irq_id_i]) ? int'(irq_id_i) : 0;
         nip[0]  = 1'b0;
         nact[0] = 1'b0;
         for (int i = 1; i < N; i++) begin
            nip[i]  = (g == i) ? 1'b0 : (m_ip[i] | (src_i[i] & ~m_act[i]));
            nact[i] = (g == i) ? 1'b1 : ((complete_i && cid == i) ? 1'b0 : m_act[i]);
         end
         @(posedge clk);
         #1;
         m_err    = complete_i && (cid == 0 || !(m_act[cid] || (g != 0 && g == cid)));
         m_ip     = nip;
         m_act    = nact;
         m_lock   = hs ? SC : ((m_lock > 0) ? m_lock - 1 : 0);
         m_rvalid = hs;
         if (hs) m_id = g;
      end
      tgt_irq = (best != 0);
      tgt_id  = best;
      compare_all();
   endtask

   task automatic idle_inputs();
      claim_valid_i = 1'b0;
      complete_i    = 1'b0;
      complete_id_i = '0;
      irq_i         = 1'b0;
      irq_id_i      = '0;
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      step();
      rst_i = 1'b0;
   endtask

   initial begin
      int lowc;
      int grants [$];
      int act_list [$];
      logic [N-1:0] all_but_0;

      for (int i = 0; i < N; i++) begin
         m_ip[i]  = 1'b0;
         m_act[i] = 1'b0;
      end
      m_lock = 0; m_rvalid = 1'b0; m_err = 1'b0; m_id = 0;
      tgt_mode = 1'b0; tgt_irq = 1'b0; tgt_id = 0;
      idle_inputs();

      // Reset held with every source asserted, then release.
      rst_i = 1'b1;
      src_i = '1;
      step();
      step();
      chk("t1_ip_rst",     ip_o, 0);
      chk("t1_act_rst",    active_o, 0);
      chk("t1_ready_rst",  claim_ready_o, 0);
      chk("t1_rvalid_rst", claim_rvalid_o, 0);
      rst_i = 1'b0;
      step();
      all_but_0 = {{(N-1){1'b1}}, 1'b0};
      chk("t1_ip_rel",    ip_o, all_but_0);
      chk("t1_ready_rel", claim_ready_o, 1);

      // Single claim of source 5.
      src_i = '0;
      do_reset();
      step();
      src_i[5] = 1'b1;
      step();
      claim_valid_i = 1'b1; irq_i = 1'b1; irq_id_i = W'(5);
      step();
      chk("t2_rvalid", claim_rvalid_o, 1);
      chk("t2_id",     claim_id_o, 5);
      chk("t2_ip5",    ip_o[5], 0);
      chk("t2_act5",   active_o[5], 1);
      idle_inputs();
      lowc = 0;
      for (int k = 0; k < 10; k++) begin
         if (claim_ready_o) break;
         lowc++;
         step();
      end
      chk("t2_lockout_cycles", lowc, SC);

      // Complete 5 with source still high; second complete is an error.
      complete_i = 1'b1; complete_id_i = W'(5);
      step();
      chk("t3_act5",  active_o[5], 0);
      chk("t3_ip5_a", ip_o[5], 0);
      chk("t3_err_a", complete_err_o, 0);
      complete_i = 1'b0;
      step();
      chk("t3_ip5_b", ip_o[5], 1);
      complete_i = 1'b1;
      step();
      chk("t3_err_b", complete_err_o, 1);
      complete_i = 1'b0;
      step();
      chk("t3_err_c", complete_err_o, 0);

      // Claim with no irq, then with a stale ID.
      claim_valid_i = 1'b1; irq_i = 1'b0;
      step();
      chk("t4_rvalid_a", claim_rvalid_o, 1);
      chk("t4_id_a",     claim_id_o, 0);
      chk("t4_ip5",      ip_o[5], 1);
      claim_valid_i = 1'b0;
      repeat (SC + 1) step();
      claim_valid_i = 1'b1; irq_i = 1'b1; irq_id_i = W'(7);
      step();
      chk("t4_id_stale", claim_id_o, 0);
      chk("t4_act",      active_o, 0);
      idle_inputs();
      repeat (SC + 1) step();

      // Back-to-back claims with a registered target.
      src_i = '0;
      do_reset();
      src_i[3] = 1'b1;
      src_i[9] = 1'b1;
      tgt_mode = 1'b1;
      step();
      step();
      claim_valid_i = 1'b1;
      for (int k = 0; k < 12; k++) begin
         step();
         if (claim_rvalid_o) grants.push_back(int'(claim_id_o));
      end
      chk("t5_grant_count", grants.size() >= 3, 1);
      if (grants.size() >= 3) begin
         chk("t5_first",  grants[0], 9);
         chk("t5_second", grants[1], 3);
         chk("t5_third",  grants[2], 0);
      end
      tgt_mode = 1'b0;
      idle_inputs();
      repeat (SC + 1) step();

      // Claim and complete of the same ID together, then reset during lockout.
      src_i = '0;
      do_reset();
      src_i[4] = 1'b1;
      step();
      src_i = '0;
      claim_valid_i = 1'b1; irq_i = 1'b1; irq_id_i = W'(4);
      complete_i = 1'b1; complete_id_i = W'(4);
      step();
      chk("t6_act4", active_o[4], 1);
      chk("t6_ip4",  ip_o[4], 0);
      chk("t6_err",  complete_err_o, 0);
      idle_inputs();
      step();
      chk("t6_in_lockout", claim_ready_o, 0);
      rst_i = 1'b1;
      step();
      chk("t6_ip_rst",     ip_o, 0);
      chk("t6_act_rst",    active_o, 0);
      chk("t6_rvalid_rst", claim_rvalid_o, 0);
      rst_i = 1'b0;
      step();
      chk("t6_ready_rel", claim_ready_o, 1);

      // Randomized traffic.
      for (int c = 0; c < 4000; c++) begin
         rst_i = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 3) == 0) src_i[$urandom_range(0, N - 1)] ^= 1'b1;
         if ($urandom_range(0, 63) == 0) src_i = '0;
         claim_valid_i = ($urandom_range(0, 2) == 0);
         tgt_mode = ($urandom_range(0, 3) != 0);
         if (!tgt_mode) begin
            irq_i    = $urandom_range(0, 1) == 1;
            irq_id_i = W'($urandom_range(0, N - 1));
         end
         complete_i = ($urandom_range(0, 3) == 0);
         act_list.delete();
         for (int i = 1; i < N; i++) if (m_act[i]) act_list.push_back(i);
         if (act_list.size() > 0 && $urandom_range(0, 9) < 7)
            complete_id_i = W'(act_list[$urandom_range(0, act_list.size() - 1)]);
         else
            complete_id_i = W'($urandom_range(0, N - 1));
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
